// File: rtl/road_vehicle_controller_if.sv
// Frame-level handshake and sprite-state bundle for road_vehicle_controller.
// master drives frame/key/collision inputs; slave (the controller) returns sprite state.
interface road_vehicle_controller_if #(
   parameter int unsigned SPEED_W = 10
);
   logic               frame_start;
   logic               game_restart;
   logic               accel_key;
   logic               brake_key;
   logic               right_key;
   logic               left_key;
   logic               car_hit;
   logic               finish_hit;
   logic [10:0]        img_id;
   logic [10:0]        pos_x;
   logic [10:0]        pos_y;
   logic [10:0]        width;
   logic [10:0]        height;
   logic [SPEED_W-1:0] speed;
   logic               crashed;
   logic               finished;
   logic               invulnerable;
   logic [7:0]         crash_count;

   modport master (
      output frame_start, game_restart, accel_key, brake_key, right_key, left_key,
             car_hit, finish_hit,
      input  img_id, pos_x, pos_y, width, height, speed, crashed, finished,
             invulnerable, crash_count
   );

   modport slave (
      input  frame_start, game_restart, accel_key, brake_key, right_key, left_key,
             car_hit, finish_hit,
      output img_id, pos_x, pos_y, width, height, speed, crashed, finished,
             invulnerable, crash_count
   );
endinterface

// File: rtl/road_vehicle_controller.sv
// Per-frame player vehicle controller: DRIVE/CRASH/RESPAWN/FINISHED FSM driving sprite state and speed.
// Define SPEED_DECAY_EN to make speed coast down by DECAY per frame when no pedal is pressed.
module road_vehicle_controller #(
   parameter int unsigned X_MIN           = 166,
   parameter int unsigned X_MAX           = 414,
   parameter int unsigned START_X         = 272,
   parameter int unsigned START_Y         = 380,
   parameter int unsigned CAR_W           = 64,
   parameter int unsigned CAR_H           = 64,
   parameter int unsigned MAX_SPEED       = 512,
   parameter int unsigned ACCEL           = 3,
   parameter int unsigned BRAKE           = 10,
   parameter int unsigned DECAY           = 2,
   parameter int unsigned STEER_STEP      = 2,
   parameter int unsigned DEATH_IMG_BASE  = 99,
   parameter int unsigned ANIM_STEPS      = 13,
   parameter int unsigned FRAMES_PER_STEP = 8,
   parameter int unsigned RESPAWN_FRAMES  = 60,
   parameter int unsigned SPEED_W         = 10
) (
   input logic                      clk,
   input logic                      resetN,
   road_vehicle_controller_if.slave bus
);

   localparam int unsigned CRASH_FRAMES = ANIM_STEPS * FRAMES_PER_STEP;
   localparam int unsigned CNT_MAX = (CRASH_FRAMES > RESPAWN_FRAMES) ? CRASH_FRAMES : RESPAWN_FRAMES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned SUB_W   = $clog2(FRAMES_PER_STEP + 1);

   localparam logic [10:0] X_LEFT   = 11'(X_MIN);
   localparam logic [10:0] X_RIGHT  = 11'(X_MAX - CAR_W);
   localparam logic [10:0] SPAWN_X  = 11'(START_X);
   localparam logic [10:0] STEP     = 11'(STEER_STEP);
   localparam logic [10:0] IMG_BASE = 11'(DEATH_IMG_BASE);

   localparam logic [SPEED_W:0] ACC_V = (SPEED_W+1)'(ACCEL);
   localparam logic [SPEED_W:0] BRK_V = (SPEED_W+1)'(BRAKE);
   localparam logic [SPEED_W:0] MAX_V = (SPEED_W+1)'(MAX_SPEED);

   typedef enum logic [1:0] {DRIVE, CRASH, RESPAWN, FINISHED} state_t;

   state_t             state, state_n;
   logic [10:0]        img, img_n;
   logic [10:0]        pos, pos_n;
   logic [SPEED_W-1:0] speed, speed_n;
   logic [7:0]         count, count_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [SUB_W-1:0]   sub, sub_n;
   logic               dir_right, dir_n;
   logic               crash_now;

   logic [SPEED_W:0]   sp_ext, sp_accel, sp_accel_sat, sp_brake, sp_coast;
   logic               right_ok, left_ok;

   assign sp_ext       = {1'b0, speed};
   assign sp_accel     = sp_ext + ACC_V;
   assign sp_accel_sat = (sp_accel > MAX_V) ? MAX_V : sp_accel;
   assign sp_brake     = (sp_ext <= BRK_V) ? '0 : sp_ext - BRK_V;

`ifdef SPEED_DECAY_EN
   localparam logic [SPEED_W:0] DEC_V = (SPEED_W+1)'(DECAY);
   assign sp_coast = (sp_ext <= DEC_V) ? '0 : sp_ext - DEC_V;
`else
   logic unused_decay;
   assign unused_decay = |32'(DECAY);
   assign sp_coast     = sp_ext;
`endif

   // Wall tests are done in 12 bits so the left-edge subtraction can never wrap.
   assign right_ok = ({1'b0, pos} + {1'b0, STEP}) <= {1'b0, X_RIGHT};
   assign left_ok  = {1'b0, pos} >= ({1'b0, X_LEFT} + {1'b0, STEP});

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= DRIVE;
         img       <= '0;
         pos       <= SPAWN_X;
         speed     <= '0;
         count     <= '0;
         cnt       <= '0;
         sub       <= '0;
         dir_right <= 1'b1;
      end else if (bus.game_restart) begin
         state     <= DRIVE;
         img       <= '0;
         pos       <= SPAWN_X;
         speed     <= '0;
         count     <= '0;
         cnt       <= '0;
         sub       <= '0;
         dir_right <= 1'b1;
      end else begin
         state     <= state_n;
         img       <= img_n;
         pos       <= pos_n;
         speed     <= speed_n;
         count     <= count_n;
         cnt       <= cnt_n;
         sub       <= sub_n;
         dir_right <= dir_n;
      end
   end

   always_comb begin
      state_n   = state;
      img_n     = img;
      pos_n     = pos;
      speed_n   = speed;
      count_n   = count;
      cnt_n     = cnt;
      sub_n     = sub;
      dir_n     = dir_right;
      crash_now = 1'b0;

      if (bus.frame_start) begin
         case (state)
            DRIVE, RESPAWN: begin
               if (bus.car_hit && state == DRIVE) begin
                  crash_now = 1'b1;
               end else if (bus.finish_hit) begin
                  state_n = FINISHED;
               end else begin
                  if (bus.brake_key)      speed_n = sp_brake[SPEED_W-1:0];
                  else if (bus.accel_key) speed_n = sp_accel_sat[SPEED_W-1:0];
                  else                    speed_n = sp_coast[SPEED_W-1:0];

                  if (bus.right_key != bus.left_key) begin
                     dir_n = bus.right_key;
                     if (bus.right_key) begin
                        if (right_ok) pos_n = pos + STEP;
                        else          crash_now = 1'b1;
                     end else begin
                        if (left_ok)  pos_n = pos - STEP;
                        else          crash_now = 1'b1;
                     end
                  end

                  if (state == RESPAWN && !crash_now) begin
                     if (cnt == CNT_W'(RESPAWN_FRAMES - 1)) begin
                        state_n = DRIVE;
                        cnt_n   = '0;
                     end else begin
                        cnt_n = cnt + 1'b1;
                     end
                  end
               end
            end

            CRASH: begin
               if (cnt == CNT_W'(CRASH_FRAMES)) begin
                  state_n = RESPAWN;
                  pos_n   = SPAWN_X;
                  img_n   = '0;
                  cnt_n   = '0;
                  sub_n   = '0;
               end else begin
                  // sub tracks cnt mod FRAMES_PER_STEP so the image step needs no divider
                  if (cnt != '0 && sub == '0) img_n = img + 11'd1;
                  sub_n = (sub == SUB_W'(FRAMES_PER_STEP - 1)) ? '0 : sub + 1'b1;
                  cnt_n = cnt + 1'b1;
                  if (dir_right) pos_n = (pos >= X_RIGHT) ? X_RIGHT : pos + 11'd1;
                  else           pos_n = (pos <= X_LEFT)  ? X_LEFT  : pos - 11'd1;
               end
            end

            FINISHED: speed_n = sp_brake[SPEED_W-1:0];

            default: state_n = DRIVE;
         endcase

         if (crash_now) begin
            state_n = CRASH;
            speed_n = '0;
            count_n = (count == 8'hFF) ? count : count + 8'd1;
            cnt_n   = '0;
            sub_n   = '0;
            img_n   = IMG_BASE;
            pos_n   = pos;
         end
      end
   end

   assign bus.img_id       = img;
   assign bus.pos_x        = pos;
   assign bus.pos_y        = 11'(START_Y);
   assign bus.width        = 11'(CAR_W);
   assign bus.height       = 11'(CAR_H);
   assign bus.speed        = speed;
   assign bus.crashed      = (state == CRASH);
   assign bus.finished     = (state == FINISHED);
   assign bus.invulnerable = (state == RESPAWN);
   assign bus.crash_count  = count;

endmodule

// File: tb/tb_road_vehicle_controller.sv
// Directed self-checking bench for road_vehicle_controller (default parameters).
// Expectations for the coasting case follow SPEED_DECAY_EN as compiled.
module tb_road_vehicle_controller;

   logic clk = 1'b0;
   logic resetN;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   road_vehicle_controller_if #(.SPEED_W(10)) bus ();

   road_vehicle_controller dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   task automatic clear_inputs();
      bus.frame_start  = 1'b0;
      bus.game_restart = 1'b0;
      bus.accel_key    = 1'b0;
      bus.brake_key    = 1'b0;
      bus.right_key    = 1'b0;
      bus.left_key     = 1'b0;
      bus.car_hit      = 1'b0;
      bus.finish_hit   = 1'b0;
   endtask

   // One frame_start pulse; returns on the following negedge with outputs settled.
   task automatic frame();
      @(negedge clk) bus.frame_start = 1'b1;
      @(negedge clk) bus.frame_start = 1'b0;
   endtask

   task automatic restart();
      @(negedge clk) bus.game_restart = 1'b1;
      @(negedge clk) bus.game_restart = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      resetN = 1'b0;
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      vectors++; if (bus.img_id !== 11'd0) begin miscompares++; $display("FAIL reset img_id got %0d exp 0", bus.img_id); end
      vectors++; if (bus.pos_x !== 11'd272) begin miscompares++; $display("FAIL reset pos_x got %0d exp 272", bus.pos_x); end
      vectors++; if (bus.pos_y !== 11'd380) begin miscompares++; $display("FAIL reset pos_y got %0d exp 380", bus.pos_y); end
      vectors++; if (bus.width !== 11'd64 || bus.height !== 11'd64) begin miscompares++; $display("FAIL reset size got %0dx%0d exp 64x64", bus.width, bus.height); end
      vectors++; if (bus.speed !== 10'd0) begin miscompares++; $display("FAIL reset speed got %0d exp 0", bus.speed); end
      vectors++; if ({bus.crashed, bus.finished, bus.invulnerable} !== 3'b000) begin miscompares++; $display("FAIL reset flags got %b exp 000", {bus.crashed, bus.finished, bus.invulnerable}); end
      vectors++; if (bus.crash_count !== 8'd0) begin miscompares++; $display("FAIL reset crash_count got %0d exp 0", bus.crash_count); end
   endtask

   task automatic test_accel();
      int exp;
      bus.accel_key = 1'b1;
      repeat (4) @(negedge clk);
      vectors++; if (bus.speed !== 10'd0) begin miscompares++; $display("FAIL accel_no_frame speed got %0d exp 0", bus.speed); end
      for (int f = 1; f <= 172; f++) begin
         frame();
         exp = (3 * f > 512) ? 512 : 3 * f;
         vectors++; if (int'(bus.speed) !== exp) begin miscompares++; $display("FAIL accel f=%0d speed got %0d exp %0d", f, bus.speed, exp); end
      end
   endtask

   task automatic test_brake();
      int exp;
      bus.accel_key = 1'b1;
      bus.brake_key = 1'b1;
      for (int f = 1; f <= 53; f++) begin
         frame();
         exp = (512 - 10 * f < 0) ? 0 : 512 - 10 * f;
         vectors++; if (int'(bus.speed) !== exp) begin miscompares++; $display("FAIL brake f=%0d speed got %0d exp %0d", f, bus.speed, exp); end
      end
      clear_inputs();
   endtask

   task automatic test_wall();
      restart();
      bus.right_key = 1'b1;
      for (int f = 1; f <= 39; f++) begin
         frame();
         vectors++; if (int'(bus.pos_x) !== 272 + 2 * f || bus.crashed !== 1'b0) begin miscompares++; $display("FAIL wall_steer f=%0d pos_x got %0d crashed %b exp %0d 0", f, bus.pos_x, bus.crashed, 272 + 2 * f); end
      end
      frame();
      vectors++; if (bus.crashed !== 1'b1 || bus.speed !== 10'd0) begin miscompares++; $display("FAIL wall_crash crashed %b speed %0d exp 1 0", bus.crashed, bus.speed); end
      vectors++; if (bus.crash_count !== 8'd1 || bus.img_id !== 11'd99) begin miscompares++; $display("FAIL wall_crash count %0d img %0d exp 1 99", bus.crash_count, bus.img_id); end
      vectors++; if (bus.pos_x !== 11'd350) begin miscompares++; $display("FAIL wall_crash pos_x got %0d exp 350", bus.pos_x); end
      clear_inputs();
   endtask

   task automatic test_crash_anim();
      int exp_img;
      for (int k = 1; k <= 104; k++) begin
         if (k >= 50 && k <= 52) begin
            bus.car_hit = 1'b1; bus.finish_hit = 1'b1; bus.accel_key = 1'b1; bus.left_key = 1'b1;
         end else clear_inputs();
         frame();
         exp_img = 99 + (k - 1) / 8;
         vectors++; if (int'(bus.img_id) !== exp_img || bus.crashed !== 1'b1) begin miscompares++; $display("FAIL anim k=%0d img got %0d crashed %b exp %0d 1", k, bus.img_id, bus.crashed, exp_img); end
         vectors++; if (bus.pos_x !== 11'd350 || bus.speed !== 10'd0 || bus.finished !== 1'b0) begin miscompares++; $display("FAIL anim_hold k=%0d pos %0d speed %0d fin %b exp 350 0 0", k, bus.pos_x, bus.speed, bus.finished); end
      end
      clear_inputs();
      frame();
      vectors++; if ({bus.invulnerable, bus.crashed} !== 2'b10 || bus.pos_x !== 11'd272 || bus.img_id !== 11'd0) begin miscompares++; $display("FAIL respawn_entry inv %b cr %b pos %0d img %0d exp 1 0 272 0", bus.invulnerable, bus.crashed, bus.pos_x, bus.img_id); end
      for (int r = 1; r <= 60; r++) begin
         bus.car_hit = (r <= 3);
         frame();
         vectors++; if (bus.invulnerable !== (r < 60) || bus.crashed !== 1'b0 || bus.crash_count !== 8'd1) begin miscompares++; $display("FAIL respawn r=%0d inv %b cr %b count %0d exp %b 0 1", r, bus.invulnerable, bus.crashed, bus.crash_count, (r < 60)); end
      end
      bus.car_hit = 1'b1;
      frame();
      vectors++; if (bus.crashed !== 1'b1 || bus.crash_count !== 8'd2 || bus.img_id !== 11'd99) begin miscompares++; $display("FAIL drive_hit cr %b count %0d img %0d exp 1 2 99", bus.crashed, bus.crash_count, bus.img_id); end
      clear_inputs();
   endtask

   task automatic test_steer();
      restart();
      bus.right_key = 1'b1;
      frame(); frame();
      vectors++; if (bus.pos_x !== 11'd276) begin miscompares++; $display("FAIL steer_right pos_x got %0d exp 276", bus.pos_x); end
      bus.right_key = 1'b0; bus.left_key = 1'b1;
      frame();
      vectors++; if (bus.pos_x !== 11'd274) begin miscompares++; $display("FAIL steer_left pos_x got %0d exp 274", bus.pos_x); end
      bus.right_key = 1'b1;
      frame();
      vectors++; if (bus.pos_x !== 11'd274) begin miscompares++; $display("FAIL steer_both pos_x got %0d exp 274", bus.pos_x); end
      clear_inputs();
      bus.car_hit = 1'b1;
      frame();
      vectors++; if (bus.crashed !== 1'b1 || bus.pos_x !== 11'd274 || bus.crash_count !== 8'd1) begin miscompares++; $display("FAIL steer_hit cr %b pos %0d count %0d exp 1 274 1", bus.crashed, bus.pos_x, bus.crash_count); end
      bus.car_hit = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         frame();
         vectors++; if (int'(bus.pos_x) !== 274 - k) begin miscompares++; $display("FAIL drift_left k=%0d pos_x got %0d exp %0d", k, bus.pos_x, 274 - k); end
      end
      @(negedge clk) bus.game_restart = 1'b1;
      @(negedge clk);
      vectors++; if (bus.crashed !== 1'b0 || bus.crash_count !== 8'd0 || bus.pos_x !== 11'd272 || bus.img_id !== 11'd0) begin miscompares++; $display("FAIL restart_crash cr %b count %0d pos %0d img %0d exp 0 0 272 0", bus.crashed, bus.crash_count, bus.pos_x, bus.img_id); end
      bus.game_restart = 1'b0;
   endtask

   task automatic test_priority();
      restart();
      bus.car_hit = 1'b1; bus.finish_hit = 1'b1;
      frame();
      vectors++; if ({bus.crashed, bus.finished} !== 2'b10 || bus.crash_count !== 8'd1) begin miscompares++; $display("FAIL both_hits cr %b fin %b count %0d exp 1 0 1", bus.crashed, bus.finished, bus.crash_count); end
      clear_inputs();
   endtask

   task automatic test_finish();
      restart();
      bus.accel_key = 1'b1;
      repeat (40) frame();
      bus.brake_key = 1'b1;
      repeat (2) frame();
      vectors++; if (bus.speed !== 10'd100) begin miscompares++; $display("FAIL finish_setup speed got %0d exp 100", bus.speed); end
      bus.brake_key = 1'b0; bus.finish_hit = 1'b1;
      frame();
      vectors++; if (bus.finished !== 1'b1 || bus.speed !== 10'd100) begin miscompares++; $display("FAIL finish_entry fin %b speed %0d exp 1 100", bus.finished, bus.speed); end
      bus.finish_hit = 1'b0; bus.car_hit = 1'b1; bus.right_key = 1'b1;
      for (int f = 1; f <= 11; f++) begin
         frame();
         vectors++; if (int'(bus.speed) !== ((f >= 10) ? 0 : 100 - 10 * f) || bus.finished !== 1'b1 || bus.crashed !== 1'b0 || bus.pos_x !== 11'd272) begin miscompares++; $display("FAIL finish_brake f=%0d speed %0d fin %b cr %b pos %0d exp %0d 1 0 272", f, bus.speed, bus.finished, bus.crashed, bus.pos_x, (f >= 10) ? 0 : 100 - 10 * f); end
      end
      clear_inputs();
      @(negedge clk) bus.game_restart = 1'b1;
      @(negedge clk);
      vectors++; if (bus.finished !== 1'b0 || bus.speed !== 10'd0 || bus.img_id !== 11'd0) begin miscompares++; $display("FAIL restart_finish fin %b speed %0d img %0d exp 0 0 0", bus.finished, bus.speed, bus.img_id); end
      bus.game_restart = 1'b0;
   endtask

   task automatic test_decay();
      int exp;
      restart();
      bus.accel_key = 1'b1;
      repeat (5) frame();
      bus.accel_key = 1'b0; bus.brake_key = 1'b1;
      frame();
      vectors++; if (bus.speed !== 10'd5) begin miscompares++; $display("FAIL decay_setup speed got %0d exp 5", bus.speed); end
      bus.brake_key = 1'b0;
      for (int f = 1; f <= 3; f++) begin
         frame();
`ifdef SPEED_DECAY_EN
         exp = (f == 1) ? 3 : (f == 2) ? 1 : 0;
`else
         exp = 5;
`endif
         vectors++; if (int'(bus.speed) !== exp) begin miscompares++; $display("FAIL coast f=%0d speed got %0d exp %0d", f, bus.speed, exp); end
      end
   endtask

   initial begin
      clear_inputs();
      resetN = 1'b0;
      test_reset();
      test_accel();
      test_brake();
      test_wall();
      test_crash_anim();
      test_steer();
      test_priority();
      test_finish();
      test_decay();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
